// File: rtl/instruction_fetch.sv
// Instruction fetch stage: issues one word fetch at a time, parks the returned
// instruction in a single output slot, and discards responses orphaned by redirects.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        id_ready,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_pc_plus4
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DROP  = 2'd2
  } state_t;

  state_t state_reg, state_next;
  // PC kept as a word address so the byte offset can never become non-zero.
  logic [29:0] pc_reg, pc_next;
  logic        inst_valid_reg, inst_valid_next;
  logic [31:0] inst_reg, inst_next;
  logic [31:0] inst_pc_reg, inst_pc_next;
  logic [31:0] inst_pc_plus4_reg, inst_pc_plus4_next;

  logic slot_free;
  logic req_fire;
  logic consume;
  logic unused_redirect_bits;

  assign unused_redirect_bits = ^redirect_pc[1:0];

  always_comb begin
    slot_free          = !inst_valid_reg || id_ready;
    imem_req_valid     = (state_reg == FETCH) && slot_free && !redirect_valid && !reset;
    req_fire           = imem_req_valid && imem_req_ready;
    consume            = inst_valid_reg && id_ready;

    state_next         = state_reg;
    pc_next            = pc_reg;
    inst_valid_next    = inst_valid_reg && !consume;
    inst_next          = inst_reg;
    inst_pc_next       = inst_pc_reg;
    inst_pc_plus4_next = inst_pc_plus4_reg;

    if (redirect_valid) begin
      pc_next         = redirect_pc[31:2];
      inst_valid_next = 1'b0;
      // A request still in flight must be swallowed before fetching again.
      case (state_reg)
        WAIT:    state_next = imem_rsp_valid ? FETCH : DROP;
        DROP:    state_next = imem_rsp_valid ? FETCH : DROP;
        default: state_next = FETCH;
      endcase
    end else begin
      case (state_reg)
        FETCH: begin
          if (req_fire) begin
            state_next = WAIT;
            pc_next    = pc_reg + 30'd1;
          end
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            state_next         = FETCH;
            inst_valid_next    = 1'b1;
            inst_next          = imem_rsp_data;
            inst_pc_next       = {pc_reg - 30'd1, 2'b00};
            inst_pc_plus4_next = {pc_reg, 2'b00};
          end
        end
        DROP: begin
          if (imem_rsp_valid) begin
            state_next = FETCH;
          end
        end
        default: state_next = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg         <= FETCH;
      pc_reg            <= RESET_PC[31:2];
      inst_valid_reg    <= 1'b0;
      inst_reg          <= NOP;
      inst_pc_reg       <= 32'h0000_0000;
      inst_pc_plus4_reg <= 32'h0000_0000;
    end else begin
      state_reg         <= state_next;
      pc_reg            <= pc_next;
      inst_valid_reg    <= inst_valid_next;
      inst_reg          <= inst_next;
      inst_pc_reg       <= inst_pc_next;
      inst_pc_plus4_reg <= inst_pc_plus4_next;
    end
  end

  assign imem_addr     = {pc_reg, 2'b00};
  assign inst_valid    = inst_valid_reg;
  assign inst          = inst_reg;
  assign inst_pc       = inst_pc_reg;
  assign inst_pc_plus4 = inst_pc_plus4_reg;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: cycle table with expected handshake values, plus a
// memory model and scoreboard checking every delivered instruction and held slot.
module tb_instruction_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        id_ready;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc_plus4;

  instruction_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .id_ready       (id_ready),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_pc_plus4  (inst_pc_plus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        idr;
    int          lat;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_iv;
    logic [31:0] exp_ipc;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  vec_t        vecs[$];
  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = 32'h0;
  int          cur_lat = 1;
  logic [31:0] exp_pc = RESET_PC;
  logic        hold_pending = 1'b0;
  logic [31:0] h_inst, h_pc, h_p4;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic void check(input bit ok, input string name,
                                input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endfunction

  function automatic vec_t mk(input logic rst, input logic rv, input logic [31:0] rpc,
                              input logic rdy, input logic idr, input int lat,
                              input logic req, input logic [31:0] addr,
                              input logic iv, input logic [31:0] ipc);
    vec_t v;
    v.rst = rst; v.rv = rv; v.rpc = rpc; v.rdy = rdy; v.idr = idr; v.lat = lat;
    v.exp_req = req; v.exp_addr = addr; v.exp_iv = iv; v.exp_ipc = ipc;
    return v;
  endfunction

  // Drive one cycle's inputs; the memory answers pend_cnt cycles after acceptance.
  task automatic drive(input logic rst, input logic rv, input logic [31:0] rpc,
                       input logic rdy, input logic idr, input int lat);
    reset          = rst;
    redirect_valid = rv;
    redirect_pc    = rpc;
    imem_req_ready = rdy;
    id_ready       = idr;
    cur_lat        = lat;
    imem_rsp_valid = (pend_cnt == 1);
    imem_rsp_data  = (pend_cnt == 1) ? mem_word(pend_addr) : 32'hDEAD_BEEF;
  endtask

  // Called at the falling edge: scoreboard and invariant checks, then advance.
  task automatic cycle_end();
    exp_t        e;
    logic        acc;
    logic [31:0] p4;
    acc = imem_req_valid && imem_req_ready;
    check(imem_addr[1:0] == 2'b00, "addr_align", imem_addr, {imem_addr[31:2], 2'b00});
    if (reset) check(!imem_req_valid, "req_in_reset", {31'b0, imem_req_valid}, 32'd0);
    if (inst_valid && !id_ready)
      check(!imem_req_valid, "req_while_full", {31'b0, imem_req_valid}, 32'd0);
    if (hold_pending) begin
      check(inst_valid == 1'b1, "hold_valid", {31'b0, inst_valid}, 32'd1);
      check(inst == h_inst, "hold_inst", inst, h_inst);
      check(inst_pc == h_pc, "hold_pc", inst_pc, h_pc);
      check(inst_pc_plus4 == h_p4, "hold_pc_plus4", inst_pc_plus4, h_p4);
    end
    if (inst_valid && id_ready) begin
      check(sb.size() != 0, "unexpected_inst", inst_pc, 32'hFFFF_FFFF);
      if (sb.size() != 0) begin
        e  = sb.pop_front();
        p4 = e.pc + 32'd4;
        $display("xfer pc=%h inst=%h pc_plus4=%h", inst_pc, inst, inst_pc_plus4);
        check(inst == e.data, "inst_data", inst, e.data);
        check(inst_pc == e.pc, "inst_pc", inst_pc, e.pc);
        check(inst_pc_plus4 == p4, "inst_pc_plus4", inst_pc_plus4, p4);
      end
    end
    if (reset || redirect_valid) sb.delete();
    if (acc) begin
      check(imem_addr == exp_pc, "fetch_addr", imem_addr, exp_pc);
      e.pc   = exp_pc;
      e.data = mem_word(exp_pc);
      sb.push_back(e);
    end
    if (reset) exp_pc = RESET_PC;
    else if (redirect_valid) exp_pc = {redirect_pc[31:2], 2'b00};
    else if (acc) exp_pc = exp_pc + 32'd4;
    hold_pending = inst_valid && !id_ready && !reset && !redirect_valid;
    h_inst = inst;
    h_pc   = inst_pc;
    h_p4   = inst_pc_plus4;
    if (pend_cnt > 0) pend_cnt--;
    if (acc) begin
      pend_cnt  = cur_lat;
      pend_addr = imem_addr;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t v;
    logic prev_rst;
    int   budget;

    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1);
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check(inst_valid == 1'b0, "rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    check(inst == NOP, "rst_inst", inst, NOP);
    check(inst_pc == 32'h0, "rst_inst_pc", inst_pc, 32'h0);
    check(inst_pc_plus4 == 32'h0, "rst_inst_pc_plus4", inst_pc_plus4, 32'h0);
    check(imem_addr == RESET_PC, "rst_addr", imem_addr, RESET_PC);
    cycle_end();

    // rst rv rpc rdy idr lat | req addr iv inst_pc
    vecs.push_back(mk(1,0,32'h0,1,1,1, 0,32'h0,0,32'h0));            // R0 reset held
    vecs.push_back(mk(0,0,32'h0,1,1,1, 1,32'h0,0,32'h0));            // streaming, zero-wait
    vecs.push_back(mk(0,0,32'h0,1,1,1, 0,32'h4,0,32'h0));
    vecs.push_back(mk(0,0,32'h0,1,1,1, 1,32'h4,1,32'h0));
    vecs.push_back(mk(0,0,32'h0,1,1,1, 0,32'h8,0,32'h0));
    vecs.push_back(mk(0,0,32'h0,1,1,1, 1,32'h8,1,32'h4));
    vecs.push_back(mk(0,0,32'h0,1,1,1, 0,32'hC,0,32'h0));
    vecs.push_back(mk(0,0,32'h0,1,1,1, 1,32'hC,1,32'h8));
    vecs.push_back(mk(0,0,32'h0,1,1,1, 0,32'h10,0,32'h0));
    vecs.push_back(mk(0,0,32'h0,1,1,1, 1,32'h10,1,32'hC));
    vecs.push_back(mk(0,0,32'h0,1,1,1, 0,32'h14,0,32'h0));
    vecs.push_back(mk(1,1,32'h500,1,1,1, 0,32'h14,1,32'h10));        // reset beats redirect
    vecs.push_back(mk(0,0,32'h0,1,1,1, 1,32'h0,0,32'h0));            // decode stall
    vecs.push_back(mk(0,0,32'h0,1,1,1, 0,32'h4,0,32'h0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0,0,32'h0,1,0,1, 0,32'h4,1,32'h0));
    vecs.push_back(mk(0,0,32'h0,1,1,1, 1,32'h4,1,32'h0));
    vecs.push_back(mk(0,0,32'h0,1,1,1, 0,32'h8,0,32'h0));
    vecs.push_back(mk(0,0,32'h0,0,1,1, 1,32'h8,1,32'h4));            // memory not ready x3
    vecs.push_back(mk(0,0,32'h0,0,1,1, 1,32'h8,0,32'h0));
    vecs.push_back(mk(0,0,32'h0,0,1,1, 1,32'h8,0,32'h0));
    vecs.push_back(mk(0,0,32'h0,1,1,1, 1,32'h8,0,32'h0));
    vecs.push_back(mk(0,0,32'h0,1,1,1, 0,32'hC,0,32'h0));
    vecs.push_back(mk(0,0,32'h0,1,1,1, 1,32'hC,1,32'h8));
    vecs.push_back(mk(0,0,32'h0,1,1,1, 0,32'h10,0,32'h0));
    vecs.push_back(mk(0,0,32'h0,1,1,2, 1,32'h10,1,32'hC));           // slow response
    vecs.push_back(mk(0,1,32'h103,1,1,1, 0,32'h14,0,32'h0));         // redirect in WAIT
    vecs.push_back(mk(0,0,32'h0,1,1,1, 0,32'h100,0,32'h0));          // DROP eats response
    vecs.push_back(mk(0,0,32'h0,1,1,1, 1,32'h100,0,32'h0));
    vecs.push_back(mk(0,0,32'h0,1,1,1, 0,32'h104,0,32'h0));
    vecs.push_back(mk(0,0,32'h0,1,1,1, 1,32'h104,1,32'h100));
    vecs.push_back(mk(0,1,32'h200,1,1,1, 0,32'h108,0,32'h0));        // redirect with response
    vecs.push_back(mk(0,0,32'h0,1,1,1, 1,32'h200,0,32'h0));
    vecs.push_back(mk(0,0,32'h0,1,1,1, 0,32'h204,0,32'h0));
    vecs.push_back(mk(0,0,32'h0,1,1,1, 1,32'h204,1,32'h200));
    vecs.push_back(mk(0,0,32'h0,1,1,1, 0,32'h208,0,32'h0));
    vecs.push_back(mk(0,1,32'hFFFF_FFFC,1,0,1, 0,32'h208,1,32'h204)); // redirect kills held slot
    vecs.push_back(mk(0,0,32'h0,1,1,1, 1,32'hFFFF_FFFC,0,32'h0));
    vecs.push_back(mk(0,0,32'h0,1,1,1, 0,32'h0,0,32'h0));            // pc wrapped
    vecs.push_back(mk(0,0,32'h0,1,1,2, 1,32'h0,1,32'hFFFF_FFFC));
    vecs.push_back(mk(1,0,32'h0,1,1,1, 0,32'h4,0,32'h0));            // reset mid-WAIT
    vecs.push_back(mk(0,0,32'h0,1,1,1, 1,32'h0,0,32'h0));            // stale response ignored
    vecs.push_back(mk(0,0,32'h0,1,1,1, 0,32'h4,0,32'h0));
    vecs.push_back(mk(0,0,32'h0,1,1,1, 1,32'h4,1,32'h0));
    vecs.push_back(mk(0,0,32'h0,1,1,1, 0,32'h8,0,32'h0));
    vecs.push_back(mk(0,0,32'h0,1,1,1, 1,32'h8,1,32'h4));
    vecs.push_back(mk(0,0,32'h0,1,1,1, 0,32'hC,0,32'h0));
    vecs.push_back(mk(0,0,32'h0,0,1,1, 1,32'hC,1,32'h8));
    vecs.push_back(mk(0,0,32'h0,0,1,1, 1,32'hC,0,32'h0));
    vecs.push_back(mk(0,0,32'h0,1,1,3, 1,32'hC,0,32'h0));
    vecs.push_back(mk(0,1,32'h40,1,1,1, 0,32'h10,0,32'h0));          // into DROP
    vecs.push_back(mk(0,1,32'h80,1,1,1, 0,32'h40,0,32'h0));          // redirect within DROP
    vecs.push_back(mk(0,0,32'h0,1,1,1, 0,32'h80,0,32'h0));
    vecs.push_back(mk(0,0,32'h0,1,1,1, 1,32'h80,0,32'h0));
    vecs.push_back(mk(0,0,32'h0,1,1,1, 0,32'h84,0,32'h0));
    vecs.push_back(mk(0,0,32'h0,0,1,1, 1,32'h84,1,32'h80));
    vecs.push_back(mk(0,0,32'h0,0,1,1, 1,32'h84,0,32'h0));

    prev_rst = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      drive(v.rst, v.rv, v.rpc, v.rdy, v.idr, v.lat);
      @(negedge clk);
      check(imem_req_valid == v.exp_req, $sformatf("row%0d_req_valid", i),
            {31'b0, imem_req_valid}, {31'b0, v.exp_req});
      check(imem_addr == v.exp_addr, $sformatf("row%0d_addr", i), imem_addr, v.exp_addr);
      check(inst_valid == v.exp_iv, $sformatf("row%0d_inst_valid", i),
            {31'b0, inst_valid}, {31'b0, v.exp_iv});
      if (v.exp_iv)
        check(inst_pc == v.exp_ipc, $sformatf("row%0d_inst_pc", i), inst_pc, v.exp_ipc);
      if (prev_rst && !v.rst) begin
        check(inst == NOP, $sformatf("row%0d_post_rst_inst", i), inst, NOP);
        check(inst_pc == 32'h0, $sformatf("row%0d_post_rst_pc", i), inst_pc, 32'h0);
        check(inst_pc_plus4 == 32'h0, $sformatf("row%0d_post_rst_p4", i), inst_pc_plus4, 32'h0);
      end
      prev_rst = v.rst;
      cycle_end();
    end

    // Random handshakes and redirects, checked by the scoreboard and invariants.
    for (int i = 0; i < 400; i++) begin
      drive(1'b0, $urandom_range(0, 9) == 0, $urandom,
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(1, 3));
      @(negedge clk);
      cycle_end();
    end

    budget = 0;
    while ((sb.size() != 0 || pend_cnt != 0) && budget < 20) begin
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1);
      @(negedge clk);
      cycle_end();
      budget++;
    end
    check(sb.size() == 0, "drain_scoreboard", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The parameter RESET_PC SHALL be listed as: RESET_PC, 32'h0000_0000, the PC loaded on reset.
REQ-002 The block SHALL use one clock and a reset that is synchronous and active-high.
REQ-003 The ports SHALL be, in this order, as listed in REQ-004 to REQ-016.
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 redirect_valid  in  1  branch/jump taken; load redirect_pc.
REQ-007 redirect_pc  in  32  redirect target; bits [1:0] ignored.
REQ-008 imem_req_valid  out  1  fetch request valid.
REQ-009 imem_req_ready  in  1  instruction memory accepts the request.
REQ-010 imem_addr  out  32  fetch address; word aligned.
REQ-011 imem_rsp_valid  in  1  response data valid.
REQ-012 imem_rsp_data  in  32  fetched instruction.
REQ-013 id_ready  in  1  decode stage consumes inst this cycle.
REQ-014 inst_valid  out  1  inst, inst_pc and inst_pc_plus4 hold a valid instruction.
REQ-015 inst  out  32  instruction to the decode stage.
REQ-016 inst_pc  out  32  address of inst; inst_pc_plus4  out  32  inst_pc + 4.

Function
REQ-017 The block SHALL keep exactly one memory request outstanding at most.
REQ-018 The block SHALL implement the states FETCH, WAIT, DROP and an internal PC register.
REQ-019 FETCH: imem_req_valid SHALL equal (!inst_valid || id_ready) && !redirect_valid, and imem_addr SHALL equal pc.
REQ-020 FETCH to WAIT: this transition SHALL occur when imem_req_valid && imem_req_ready; pc SHALL become pc + 4, modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
REQ-021 The request SHALL stay in FETCH while imem_req_ready is low, with imem_addr held stable; imem_req_valid SHALL NOT be withdrawn unless redirect_valid is asserted.
REQ-022 WAIT: when imem_rsp_valid is high, the output register SHALL load inst=imem_rsp_data, inst_pc=pc-4 and inst_pc_plus4=pc, inst_valid SHALL be set, and the state SHALL return to FETCH.
REQ-023 Throughput SHALL be one instruction per 2 cycles with a zero-wait memory (ready=1, response on the cycle after acceptance).
REQ-024 Latency SHALL be: inst_valid rises on the edge ending the response cycle.
REQ-025 Output handshake: inst_valid && id_ready SHALL clear inst_valid at the next edge unless a response is loaded on the same edge.
REQ-026 Output handshake: while inst_valid && !id_ready, all inst* outputs SHALL hold stable.
REQ-027 No response SHALL ever be accepted while the output slot is occupied and unconsumed; this is guaranteed by REQ-019.
REQ-028 redirect_valid SHALL have highest priority and SHALL, at the edge, set pc = {redirect_pc[31:2],2'b00} and clear inst_valid.
REQ-029 Redirect in FETCH or DROP SHALL cause next state FETCH, unless a request is still outstanding.
REQ-030 Redirect in WAIT with imem_rsp_valid in the same cycle SHALL discard the response and go to FETCH.
REQ-031 Redirect in WAIT without imem_rsp_valid SHALL go to DROP.
REQ-032 Redirect in DROP SHALL stay in DROP and update pc.
REQ-033 DROP: imem_req_valid SHALL be 0; the next imem_rsp_valid SHALL be discarded and the state SHALL go to FETCH without a response being loaded.
REQ-034 imem_rsp_valid in FETCH SHALL be ignored.
REQ-035 pc[1:0] and imem_addr[1:0] SHALL always be 2'b00.

Reset
REQ-036 Reset SHALL take priority over redirect and over all handshakes.
REQ-037 Reset SHALL set state=FETCH, pc=RESET_PC, inst_valid=0, inst=32'h0000_0013 (NOP), inst_pc=0, inst_pc_plus4=0.
REQ-038 imem_req_valid SHALL be 0 while reset is high.
REQ-039 Reset mid-WAIT SHALL drop the outstanding response, and a response arriving in the first cycle after reset SHALL be ignored.
REQ-040 The first request after reset SHALL be issued in the first cycle with reset low, with imem_addr=RESET_PC.

Verification
REQ-041 Zero-wait memory, id_ready=1, reset released: the bench SHALL check inst_valid pulses with inst_pc 0, 4, 8, 12 on alternate cycles, and inst_pc_plus4 equal to inst_pc+4.
REQ-042 id_ready=0 for 5 cycles after the first instruction: the bench SHALL check inst and inst_pc=0 held, imem_req_valid=0, and fetch of 4 resuming the cycle id_ready=1.
REQ-043 imem_req_ready low for 3 cycles: the bench SHALL check imem_req_valid=1 and imem_addr=8 held stable, with no pc advance.
REQ-044 Redirect to 32'h0000_0103 in WAIT before the response: the bench SHALL check the stale response is dropped, inst_valid=0, the next imem_addr=32'h0000_0100, and the next inst_pc=32'h100.
REQ-045 Redirect in the same cycle as imem_rsp_valid: the bench SHALL check the response is discarded and no inst_valid occurs for it.
REQ-046 Redirect to 32'hFFFF_FFFC followed by reset asserted mid-WAIT: the bench SHALL check fetch 32'hFFFF_FFFC, pc wrap to 0, and the REQ-037 outputs one cycle after reset, with a restart at RESET_PC.
